dmem_lsu: RTL and testbench
===========================

# dmem_lsu

Byte-addressed, parametrised data memory with a request/response handshake, for the load/store path of the RISC-V core. Successor to the word-indexed combinational data memory:
- accepts full byte addresses and places bytes and halfwords on little-endian lanes;
- detects misaligned and illegal accesses;
- reads synchronously through a configurable-latency response pipeline.

Sits between the execute stage and the memory-writeback mux.

## Interface
- `AddrWidth`, 12: byte-address width; depth = 2**(AddrWidth-2) 32-bit words.
- `ReadLatency`, 1: cycles from accepted request to `rsp_valid_o`; legal range 1..4.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_i`  in  1  reset; asynchronous and active-high.
- `req_valid_i`  in  1  request present this cycle.
- `req_ready_o`  out  1  block can accept a request.
- `req_we_i`  in  1  1 = store, 0 = load.
- `req_addr_i`  in  AddrWidth  byte address.
- `req_funct3_i`  in  3  RV32I load/store funct3.
- `req_wdata_i`  in  32  store data, right-aligned.
- `rsp_valid_o`  out  1  response valid, one cycle per accepted request.
- `rsp_rdata_o`  out  32  load result, extended; 0 for stores and errors.
- `rsp_err_o`  out  1  access was misaligned or illegal.

## Operation
- **Accept rule:** a request is accepted on a rising edge where `req_valid_i && req_ready_o`.
  - No backpressure on responses; one request per cycle sustained.
- **`req_ready_o`:**
  - 0 while `rst_i` is high.
  - Goes to 1 at the first rising edge after reset deassertion; stays 1 afterwards.
- **Word index** = `req_addr_i[AddrWidth-1:2]`; **lane** = `req_addr_i[1:0]`.
- **Legal loads:** 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- **Legal stores:** 000 SB, 001 SH, 010 SW.
- **Alignment:**
  - Halfword accesses need `lane[0]==0`.
  - Word accesses need `lane==0`.
- **Error:** an illegal funct3 or a misaligned access gives `rsp_err_o=1` and `rsp_rdata_o=0`.
  - A store in error writes nothing.
- **Stores:**
  - Commit at the accept edge.
  - SB writes byte lane `lane` with `wdata[7:0]`.
  - SH writes lanes `lane`, `lane+1` with `wdata[15:0]`.
  - SW writes all four lanes.
  - Unwritten lanes are preserved.
- **Loads:**
  - The word is read at the accept edge.
  - The selected byte or halfword is shifted down from its lane, then sign-extended (LB, LH) or zero-extended (LBU, LHU).
- **Every accepted request produces exactly one response**, stores included; stores return `rsp_rdata_o=0`.
- **Memory contents are not reset**; an uninitialised read returns X in simulation.

## Timing
- Request accepted at edge N → `rsp_valid_o` high during the cycle after edge N+ReadLatency-1.
  - ReadLatency=1 gives the response in the cycle following acceptance.
- Responses return in request order.
- **Response pipeline:** a shift register of ReadLatency stages, each holding valid, err, funct3, lane and data.
  - Extension is applied at the output stage.
- **Store at edge N, load of the same word at edge N+1:** the load returns the stored data; no forwarding logic is needed.
- **Store and load to the same word cannot coincide**, since there is a single port and one request per edge.
- **Reset asserted mid-operation:**
  - All pipeline valid bits clear immediately, so `rsp_valid_o`, `rsp_err_o` and `rsp_rdata_o` go to 0 asynchronously and in-flight responses are dropped.
  - A store already committed stays committed.
- **Reset values:** `req_ready_o=0`, `rsp_valid_o=0`, `rsp_err_o=0`, `rsp_rdata_o=0`.

## Structure
- **Package `dmem_pkg`:**
  - funct3 localparams `F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`.
  - Response-stage struct: valid, err, is_load, funct3, lane, word.
  - Function `is_misaligned(funct3, lane)`.
- **Sub-module `dmem_load_align`:** combinational lane select and sign/zero extension on the output stage.
  - Reused later by the cache refill path.
- **Top-level:**
  - Memory array with byte-lane write enables.
  - Request decode.
  - ReadLatency-deep response pipeline, built as a generate loop.

## Test plan
- Reset, then SW 0xDEADBEEF to address 0x010, then LW 0x010 → response in the next cycle with rdata=0xDEADBEEF, err=0; the store's own response has rdata=0.
- After that SW:
  - LB 0x013 → 0xFFFFFFDE.
  - LBU 0x013 → 0x000000DE.
  - LH 0x012 → 0xFFFFDEAD.
  - LHU 0x010 → 0x0000BEEF.
- SB 0x55 to 0x011, then LW 0x010 → 0xDEAD55EF; the other lanes are unchanged.
- SH to 0x011 and LW to 0x012 → each gets err=1 and rdata=0; a follow-up LW 0x010 shows the memory unmodified.
- ReadLatency=3 with back-to-back loads on 4 consecutive cycles → 4 in-order responses starting 3 cycles after the first accept; funct3=011 → err=1.
- Assert `rst_i` with 2 loads in flight → `rsp_valid_o` drops to 0 at once and no response appears after release; `req_ready_o` returns to 1 one edge after deassertion.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the byte-addressed data memory: RV32I load/store
// funct3 codes, the response-pipeline stage record and the access-legality
// helpers used by the request decoder.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // One slot of the read-response shift register.
  typedef struct packed {
    logic        valid;
    logic        err;
    logic        is_load;
    logic [2:0]  funct3;
    logic [1:0]  lane;
    logic [31:0] word;
  } rsp_stage_t;

  // Halfwords need an even lane, words need lane 0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3[1:0])
      2'b01:   return lane[0];
      2'b10:   return lane != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

  // Stores accept only the sized codes; loads also accept the unsigned variants.
  function automatic logic is_legal(input logic we, input logic [2:0] funct3);
    if (we) return funct3 inside {F3_B, F3_H, F3_W};
    return funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load-result formatting: shifts the addressed byte or halfword down from its
// lane and sign- or zero-extends it. Purely combinational so the cache refill
// path can reuse it unchanged.
module dmem_load_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  lane,
  input  logic [31:0] word,
  output logic [31:0] data
);

  logic [31:0] shifted;

  // Lane select followed by extension chosen by funct3.
  always_comb begin
    shifted = word >> {lane, 3'b000};
    data    = '0;
    case (funct3)
      F3_B:    data = {{24{shifted[7]}}, shifted[7:0]};
      F3_H:    data = {{16{shifted[15]}}, shifted[15:0]};
      F3_W:    data = word;
      F3_BU:   data = {24'h0, shifted[7:0]};
      F3_HU:   data = {16'h0, shifted[15:0]};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_lsu.sv
// Byte-addressed data memory with request/response handshake. Stores commit
// at the accept edge through byte-lane enables; loads read the whole word at
// the accept edge and carry it through a ReadLatency-deep response pipeline,
// with lane selection and extension applied at the output stage.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int AddrWidth   = 12,
  parameter int ReadLatency = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic                 req_we_i,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [2:0]           req_funct3_i,
  input  logic [31:0]          req_wdata_i,
  output logic                 rsp_valid_o,
  output logic [31:0]          rsp_rdata_o,
  output logic                 rsp_err_o
);

  localparam int Depth = 2 ** (AddrWidth - 2);

  logic [31:0]          mem [Depth];
  logic                 ready_q;
  logic                 accept;
  logic                 req_err;
  logic [AddrWidth-3:0] word_idx;
  logic [1:0]           lane;
  logic [3:0]           byte_en;
  logic [31:0]          lane_wdata;
  rsp_stage_t           req_stage;
  rsp_stage_t           out_stage;
  logic [31:0]          aligned;

  assign word_idx    = req_addr_i[AddrWidth-1:2];
  assign lane        = req_addr_i[1:0];
  assign accept      = req_valid_i && ready_q;
  assign req_err     = !is_legal(req_we_i, req_funct3_i) || is_misaligned(req_funct3_i, lane);
  assign req_ready_o = ready_q;

  // Ready rises at the first edge after reset release and then stays high.
  // NOTE: async reset belongs only in control/state flops; the sensitivity
  // list must name the reset edge or synthesis builds a synchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) ready_q <= 1'b0;
    else       ready_q <= 1'b1;
  end

  // Store decode: replicate the data onto every lane, then enable only the
  // addressed lanes; rejected or erroneous requests enable nothing.
  always_comb begin
    byte_en    = '0;
    lane_wdata = req_wdata_i;
    case (req_funct3_i)
      F3_B: begin
        byte_en    = 4'b0001 << lane;
        lane_wdata = {4{req_wdata_i[7:0]}};
      end
      F3_H: begin
        byte_en    = 4'b0011 << lane;
        lane_wdata = {2{req_wdata_i[15:0]}};
      end
      F3_W:    byte_en = 4'b1111;
      default: byte_en = '0;
    endcase
    if (!accept || !req_we_i || req_err) byte_en = '0;
  end

  // Byte-lane writes into the array.
  // NOTE: the memory has no reset branch on purpose -- resetting an array
  // prevents RAM inference and committed stores must survive a reset.
  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) mem[word_idx][8*b +: 8] <= lane_wdata[8*b +: 8];
    end
  end

  // Contents of the stage entered at the accept edge; the word read here is
  // what the array holds before this edge, and a store/load pair to the same
  // word can never share an edge.
  always_comb begin
    req_stage         = '0;
    req_stage.valid   = accept;
    req_stage.err     = req_err;
    req_stage.is_load = !req_we_i;
    req_stage.funct3  = req_funct3_i;
    req_stage.lane    = lane;
    req_stage.word    = mem[word_idx];
  end

  for (genvar g = 0; g < ReadLatency; g++) begin : g_stage
    rsp_stage_t q;
    rsp_stage_t d;

    if (g == 0) begin : g_head
      assign d = req_stage;
    end else begin : g_tail
      assign d = g_stage[g-1].q;
    end

    // Shift one stage per edge; reset drops every in-flight response at once.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) q <= '0;
      else       q <= d;
    end
  end

  assign out_stage = g_stage[ReadLatency-1].q;

  dmem_load_align u_load_align (
    .funct3 (out_stage.funct3),
    .lane   (out_stage.lane),
    .word   (out_stage.word),
    .data   (aligned)
  );

  assign rsp_valid_o = out_stage.valid;
  assign rsp_err_o   = out_stage.valid && out_stage.err;
  assign rsp_rdata_o = (out_stage.valid && out_stage.is_load && !out_stage.err) ? aligned : 32'h0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu. Two instances (ReadLatency 1 and 3) see the
// same request stream; each request pushes its expected response and arrival
// edge into a per-instance queue, and a monitor pops and compares whenever an
// instance presents rsp_valid_o. Expected values come from a byte-array model.
module tb_dmem_lsu;
  import dmem_pkg::*;

  localparam int AW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [2:0]    req_funct3 = '0;
  logic [31:0]   req_wdata = '0;

  logic        ready1, ready3, v1, v3, e1, e3;
  logic [31:0] d1, d3;

  dmem_lsu #(.AddrWidth(AW), .ReadLatency(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready1),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_funct3_i(req_funct3),
    .req_wdata_i(req_wdata), .rsp_valid_o(v1), .rsp_rdata_o(d1), .rsp_err_o(e1)
  );

  dmem_lsu #(.AddrWidth(AW), .ReadLatency(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid), .req_ready_o(ready3),
    .req_we_i(req_we), .req_addr_i(req_addr), .req_funct3_i(req_funct3),
    .req_wdata_i(req_wdata), .rsp_valid_o(v3), .rsp_rdata_o(d3), .rsp_err_o(e3)
  );

  always #5 clk = ~clk;

  int edge_cnt = 0;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          edge_no;
  } exp_t;

  exp_t q1[$];
  exp_t q3[$];
  logic [7:0] model_mem [int];
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: sizes, legality and alignment from the ISA rules,
  // memory as a little-endian byte array.
  function automatic void model_access(input logic we, input logic [AW-1:0] addr,
                                       input logic [2:0] f3, input logic [31:0] wdata,
                                       output logic [31:0] rdata, output logic err);
    int size;
    int a;
    logic legal;
    logic [31:0] val;
    size  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    legal = we ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    a     = int'(addr);
    err   = !legal || (a % size != 0);
    rdata = 32'h0;
    if (err) return;
    if (we) begin
      for (int i = 0; i < size; i++) model_mem[a + i] = wdata[8*i +: 8];
    end else begin
      val = 32'h0;
      for (int i = 0; i < size; i++) val = val | (32'(model_mem[a + i]) << (8 * i));
      if (!f3[2] && size < 4 && val[8*size-1]) val = val | ~((32'd1 << (8 * size)) - 32'd1);
      rdata = val;
    end
  endfunction

  // Drive one request for one cycle and push its expected response.
  task automatic issue(input logic we, input logic [AW-1:0] addr, input logic [2:0] f3,
                       input logic [31:0] wdata, input bit has_exp = 1'b0,
                       input logic [31:0] exp_rdata = 32'h0, input logic exp_err = 1'b0);
    logic [31:0] r;
    logic e;
    model_access(we, addr, f3, wdata, r, e);
    if (has_exp) begin
      r = exp_rdata;
      e = exp_err;
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_addr   = addr;
    req_funct3 = f3;
    req_wdata  = wdata;
    q1.push_back('{rdata: r, err: e, edge_no: edge_cnt + 1});
    q3.push_back('{rdata: r, err: e, edge_no: edge_cnt + 3});
    @(negedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Monitor: runs at each falling edge, before the driver changes inputs.
  initial begin
    exp_t x;
    forever begin
      @(negedge clk);
      if (v1) begin
        if (q1.size() == 0) check("lat1 unexpected response", {31'h0, v1}, 32'h0);
        else begin
          x = q1.pop_front();
          check("lat1 rdata", d1, x.rdata);
          check("lat1 err", {31'h0, e1}, {31'h0, x.err});
          check("lat1 arrival edge", 32'(edge_cnt), 32'(x.edge_no));
        end
      end
      if (v3) begin
        if (q3.size() == 0) check("lat3 unexpected response", {31'h0, v3}, 32'h0);
        else begin
          x = q3.pop_front();
          check("lat3 rdata", d3, x.rdata);
          check("lat3 err", {31'h0, e3}, {31'h0, x.err});
          check("lat3 arrival edge", 32'(edge_cnt), 32'(x.edge_no));
        end
      end
    end
  end

  initial begin
    int guard;

    // Reset state.
    repeat (3) @(negedge clk);
    #1;
    check("reset ready lat1", {31'h0, ready1}, 32'h0);
    check("reset ready lat3", {31'h0, ready3}, 32'h0);
    check("reset rsp_valid lat1", {31'h0, v1}, 32'h0);
    check("reset rsp_valid lat3", {31'h0, v3}, 32'h0);
    check("reset rsp_err", {31'h0, e1 | e3}, 32'h0);
    check("reset rsp_rdata", d1 | d3, 32'h0);
    rst = 1'b0;
    #1;
    check("ready before first edge", {31'h0, ready1}, 32'h0);
    @(posedge clk);
    #1;
    check("ready after first edge lat1", {31'h0, ready1}, 32'h1);
    check("ready after first edge lat3", {31'h0, ready3}, 32'h1);
    @(negedge clk);
    #1;

    // Fill the exercised region so every later load reads known data.
    for (int w = 0; w < 16; w++) issue(1'b1, AW'(w * 4), F3_W, $urandom);

    // Directed sequence with hand-derived expectations.
    issue(1'b1, 12'h010, F3_W,  32'hDEADBEEF, 1'b1, 32'h0,        1'b0);
    issue(1'b0, 12'h010, F3_W,  32'h0,        1'b1, 32'hDEADBEEF, 1'b0);
    issue(1'b0, 12'h013, F3_B,  32'h0,        1'b1, 32'hFFFFFFDE, 1'b0);
    issue(1'b0, 12'h013, F3_BU, 32'h0,        1'b1, 32'h000000DE, 1'b0);
    issue(1'b0, 12'h012, F3_H,  32'h0,        1'b1, 32'hFFFFDEAD, 1'b0);
    issue(1'b0, 12'h010, F3_HU, 32'h0,        1'b1, 32'h0000BEEF, 1'b0);
    issue(1'b1, 12'h011, F3_B,  32'h00000055, 1'b1, 32'h0,        1'b0);
    issue(1'b0, 12'h010, F3_W,  32'h0,        1'b1, 32'hDEAD55EF, 1'b0);
    issue(1'b1, 12'h011, F3_H,  32'h00001234, 1'b1, 32'h0,        1'b1);
    issue(1'b0, 12'h012, F3_W,  32'h0,        1'b1, 32'h0,        1'b1);
    issue(1'b0, 12'h010, F3_W,  32'h0,        1'b1, 32'hDEAD55EF, 1'b0);
    idle(4);
    // Four back-to-back loads, then illegal codes.
    issue(1'b0, 12'h010, F3_W,   32'h0,        1'b1, 32'hDEAD55EF, 1'b0);
    issue(1'b0, 12'h011, F3_BU,  32'h0,        1'b1, 32'h00000055, 1'b0);
    issue(1'b0, 12'h010, F3_H,   32'h0,        1'b1, 32'h000055EF, 1'b0);
    issue(1'b0, 12'h012, F3_HU,  32'h0,        1'b1, 32'h0000DEAD, 1'b0);
    issue(1'b0, 12'h010, 3'b011, 32'h0,        1'b1, 32'h0,        1'b1);
    issue(1'b1, 12'h010, 3'b011, 32'hFFFFFFFF, 1'b1, 32'h0,        1'b1);
    issue(1'b1, 12'h010, F3_BU,  32'hFFFFFFFF, 1'b1, 32'h0,        1'b1);
    issue(1'b0, 12'h010, F3_W,   32'h0,        1'b1, 32'hDEAD55EF, 1'b0);
    idle(5);

    // Randomised traffic against the model, all funct3 codes, mixed gaps.
    repeat (400) begin
      if ($urandom_range(0, 4) == 0) idle(1);
      else issue(1'($urandom_range(0, 1)), AW'($urandom_range(0, 63)),
                 3'($urandom_range(0, 7)), $urandom);
    end
    idle(6);

    // Reset with loads in flight: responses vanish at once, none come back.
    issue(1'b0, 12'h010, F3_W,  32'h0);
    issue(1'b0, 12'h014, F3_W,  32'h0);
    issue(1'b0, 12'h018, F3_W,  32'h0);
    issue(1'b0, 12'h01C, F3_BU, 32'h0);
    check("lat3 valid before reset", {31'h0, v3}, 32'h1);
    rst = 1'b1;
    #1;
    check("async drop rsp_valid lat1", {31'h0, v1}, 32'h0);
    check("async drop rsp_valid lat3", {31'h0, v3}, 32'h0);
    check("async drop rsp_err/rdata", {31'h0, e1 | e3} | d1 | d3, 32'h0);
    q1.delete();
    q3.delete();
    repeat (2) @(negedge clk);
    #1;
    check("ready low in reset", {31'h0, ready1 | ready3}, 32'h0);
    rst = 1'b0;
    #1;
    check("ready low right after release", {31'h0, ready1 | ready3}, 32'h0);
    @(posedge clk);
    #1;
    check("ready back one edge after release", {31'h0, ready1 & ready3}, 32'h1);
    idle(6);
    // Committed stores survive reset.
    issue(1'b0, 12'h010, F3_W, 32'h0);
    issue(1'b0, 12'h03C, F3_W, 32'h0);
    idle(2);

    // Bounded drain of outstanding expectations.
    guard = 0;
    while ((q1.size() != 0 || q3.size() != 0) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    #1;
    check("lat1 responses outstanding", 32'(q1.size()), 32'h0);
    check("lat3 responses outstanding", 32'(q3.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
